// File: rtl/mem_port_master_if.sv
// Command / write-data / read-data channels between a burst requester and
// mem_port_master. Every channel uses one rule: a beat transfers on a rising
// clock edge where valid && ready are both high; the sender holds its payload
// steady while valid is high and ready is low.
interface mem_port_master_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) ();
    // command channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    // write-data channel
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    // read-data channel
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    // requester side
    modport master (
        output req_valid, req_we, req_addr, req_len,
        input  req_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready
    );

    // mem_port_master side
    modport slave (
        input  req_valid, req_we, req_addr, req_len,
        output req_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready
    );
endinterface

// File: rtl/mem_port_master.sv
// Burst sequencer driving one port of the dual-port data memory.
// Write beats: WR_WAIT collects a beat, WR_DRIVE strobes it for one cycle.
// Read beats: RD_ISSUE strobes one cycle (memory drives the bus after its
// negedge latch), the closing edge captures the bus, RD_RSP holds the beat
// until the consumer takes it. All strobes and readies decode from state only.
module mem_port_master #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_master_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic                  mem_oe_o,
    inout  wire  [DATA_WIDTH-1:0] mem_data_io,
    output logic                  busy_o,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_DRIVE = 3'd2,
        RD_ISSUE = 3'd3,
        RD_RSP   = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q,  rd_last_d;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Next-state and datapath updates; the counter holds beats remaining
    // after the current one, so zero means this is the final beat.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    state_d = bus.req_we ? WR_WAIT : RD_ISSUE;
                end
            end
            WR_WAIT: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = WR_DRIVE;
                end
            end
            WR_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - LEN_WIDTH'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = WR_WAIT;
                end
            end
            RD_ISSUE: begin
                // memory has been driving the bus since its negedge latch
                rd_data_d  = mem_data_io;
                rd_valid_d = 1'b1;
                rd_last_d  = (cnt_q == '0);
                state_d    = RD_RSP;
            end
            RD_RSP: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and readies decoded from the state register alone.
    always_comb begin
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_oe_o      = 1'b0;
        bus.req_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        busy_o        = 1'b1;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy_o        = 1'b0;
            end
            WR_WAIT:  bus.wr_ready = 1'b1;
            WR_DRIVE: begin
                mem_cs_o = 1'b1;
                mem_we_o = 1'b1;
            end
            RD_ISSUE: begin
                mem_cs_o = 1'b1;
                mem_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    // The master only owns the bus while it is strobing a write.
    assign mem_data_io = (state_q == WR_DRIVE) ? wdata_q : {DATA_WIDTH{1'bz}};

    assign mem_addr_o   = addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_last  = rd_last_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed and randomized bursts against mem_port_master driving a
// behavioural memory; expected read data comes from a reference array
// filled from the write stimulus.
module tb_mem_port_master;
    localparam int DW = 4;
    localparam int AW = 16;
    localparam int LW = 4;
    localparam int WAIT_MAX = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    logic [AW-1:0] mem_addr;
    logic          mem_cs, mem_we, mem_oe, busy;
    logic [2:0]    dbg_state;
    tri1  [DW-1:0] mem_data;

    mem_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_addr_o  (mem_addr),
        .mem_cs_o    (mem_cs),
        .mem_we_o    (mem_we),
        .mem_oe_o    (mem_oe),
        .mem_data_io (mem_data),
        .busy_o      (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] mem_rd_q;
    always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_data;
    always @(negedge clk) if (mem_cs && mem_oe && !mem_we) mem_rd_q <= mem[mem_addr];
    assign mem_data = (mem_cs && mem_oe && !mem_we) ? mem_rd_q : {DW{1'bz}};

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wdat [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int n = 0;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check("req_ready_seen", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("busy_after_req", 32'(busy), 32'd1);
    endtask

    task automatic write_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
        int n = 0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("no_strobe_in_stall", 32'(mem_cs), 32'd0);
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        while (!bus.wr_ready && n < WAIT_MAX) begin
            tick();
            n++;
        end
        check("wr_ready_seen", 32'(bus.wr_ready), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        check("wr_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'b110);
        check("wr_bus_data", 32'(mem_data), 32'(d));
        check("wr_addr", 32'(mem_addr), 32'(a));
        tick();
        check("wr_strobe_one_cycle", 32'(mem_cs), 32'd0);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input int stall_idx,
                               input int stall_n);
        logic [AW-1:0] a;
        send_req(1'b1, addr, LW'(len));
        for (int i = 0; i <= len; i++) begin
            a = AW'(addr + i);
            write_beat(a, wdat[i], (i == stall_idx) ? stall_n : 0);
            ref_mem[int'(a)] = wdat[i];
        end
        check("wr_done_idle", 32'(busy), 32'd0);
        for (int i = 0; i <= len; i++) begin
            a = AW'(addr + i);
            check("mem_content", 32'(mem[a]), 32'(wdat[i]));
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len, input int stall_idx,
                              input int stall_n);
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[int'(AW'(addr + i))]);
        send_req(1'b0, addr, LW'(len));
        for (int i = 0; i <= len; i++) begin
            a = AW'(addr + i);
            check("rd_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'b101);
            check("rd_addr", 32'(mem_addr), 32'(a));
            check("rd_valid_not_yet", 32'(bus.rd_valid), 32'd0);
            tick();
            e = exp_q.pop_front();
            check("rd_valid", 32'(bus.rd_valid), 32'd1);
            check("rd_data", 32'(bus.rd_data), 32'(e));
            check("rd_last", 32'(bus.rd_last), (i == len) ? 32'd1 : 32'd0);
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("rd_hold_valid", 32'(bus.rd_valid), 32'd1);
                    check("rd_hold_data", 32'(bus.rd_data), 32'(e));
                    check("rd_stall_no_strobe", 32'(mem_cs), 32'd0);
                end
            end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            check("rd_valid_cleared", 32'(bus.rd_valid), 32'd0);
            check("rd_last_cleared", 32'(bus.rd_last), 32'd0);
        end
        check("rd_done_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int            rlen;
        int            wlen;
        logic [AW-1:0] raddr;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_last", 32'(bus.rd_last), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_bus_released", 32'(mem_data), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // seed location 0x0010, then reset in the middle of a write strobe
        wdat[0] = 4'h9;
        write_burst(16'h0010, 0, -1, 0);
        send_req(1'b1, 16'h0010, 4'd2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 4'h3;
        tick();
        bus.wr_valid = 1'b0;
        check("pre_rst_strobe", {30'd0, mem_cs, mem_we}, 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", 32'(mem_cs), 32'd0);
        check("async_rst_we", 32'(mem_we), 32'd0);
        check("async_rst_bus_z", 32'(mem_data), 32'hF);
        check("async_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("aborted_write_not_stored", 32'(mem[16'h0010]), 32'h9);

        // single write then read
        wdat[0] = 4'hA;
        write_burst(16'h0003, 0, -1, 0);
        read_burst(16'h0003, 0, -1, 0);

        // write burst with a 2-cycle stall before beat 3
        for (int i = 0; i < 4; i++) wdat[i] = DW'(i + 1);
        write_burst(16'h0004, 3, 2, 2);

        // read burst with 3 cycles of backpressure on beat 2
        read_burst(16'h0004, 3, 1, 3);

        // address wrap
        wdat[0] = 4'h5;
        wdat[1] = 4'h6;
        write_burst(16'hFFFF, 1, -1, 0);
        read_burst(16'hFFFF, 1, -1, 0);

        // command blocking: second read held pending through a 2-beat read
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0004;
        bus.req_len   = 4'd1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_addr  = 16'h0005;
        bus.req_len   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            check("blk_req_ready_issue", 32'(bus.req_ready), 32'd0);
            tick();
            check("blk_req_ready_rsp", 32'(bus.req_ready), 32'd0);
            check("blk_rd_data", 32'(bus.rd_data), 32'(ref_mem[4 + i]));
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
        end
        check("blk_req_ready_idle", 32'(bus.req_ready), 32'd1);
        check("blk_idle_busy", 32'(busy), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("blk_second_started", {29'd0, mem_cs, mem_we, mem_oe}, 32'b101);
        check("blk_second_addr", 32'(mem_addr), 32'h5);
        check("blk_second_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("blk_second_data", 32'(bus.rd_data), 32'(ref_mem[5]));
        check("blk_second_last", 32'(bus.rd_last), 32'd1);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        check("blk_second_done", 32'(busy), 32'd0);

        // maximum length burst (all-ones req_len)
        for (int i = 0; i < 16; i++) wdat[i] = DW'($urandom_range(0, 15));
        write_burst(16'h0100, 15, -1, 0);
        read_burst(16'h0100, 15, -1, 0);

        // randomized bursts: write a region, read back a prefix of it
        for (int t = 0; t < 8; t++) begin
            raddr = AW'($urandom_range(0, 65535));
            wlen  = $urandom_range(0, 15);
            for (int i = 0; i <= wlen; i++) wdat[i] = DW'($urandom_range(0, 15));
            write_burst(raddr, wlen, $urandom_range(0, wlen), $urandom_range(0, 3));
            rlen = $urandom_range(0, wlen);
            read_burst(raddr, rlen, $urandom_range(0, rlen), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
